// File: rtl/simple_processor_pkg.sv
// Shared datapath types and constants for the processor and its memory stage.
// Latency: none (types, constants and a pure helper only).
// Backpressure: none.
package simple_processor_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    // Upstream operation selector; encodings other than LOAD/STORE are no-ops.
    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        STORE = 2'b01
    } func_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REQ      = 2'b01,
        WAIT_RSP = 2'b10
    } mem_state_t;

    // Memory port is word addressed in bytes; the two byte-lane bits are dropped.
    localparam logic [DATA_WIDTH-1:0] MEM_ADDR_ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    function automatic logic [DATA_WIDTH-1:0] align_word_addr(input logic [DATA_WIDTH-1:0] addr);
        return addr & MEM_ADDR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the upstream request handshake, the data-memory req/gnt/rvalid port
// and the register-write return path of the memory stage.
// slave: the memory stage itself; master: whoever drives upstream and memory side.
interface mem_access_ctrl_if;
    import simple_processor_pkg::*;

    // upstream request (from alu_mem)
    logic                  valid_i;
    logic                  ready_o;
    func_t                 func_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    // data-memory port
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    // register-write return path and status
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  done_o;
    logic                  err_o;

    modport slave (
        input  valid_i, func_i, we_i, addr_i, wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output rd_data_o, rd_valid_o, done_o, err_o
    );

    modport master (
        output valid_i, func_i, we_i, addr_i, wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  rd_data_o, rd_valid_o, done_o, err_o
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Cycle counter bounding how long the memory stage waits for read data.
// Latency: expired_o is combinational from the count and enable_i.
// Backpressure: none; clear_i has priority over enable_i.
// Ports: clk_i, arst_i (async, active-high), clear_i, enable_i, expired_o.
// Only compiled when MEM_TIMEOUT_EN is defined (its sole user is guarded the same way).
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of completed waiting cycles, so this fires in the
    // TIMEOUT_CYCLES-th waiting cycle.
    assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// Memory stage after alu_mem: one LOAD/STORE at a time onto a req/gnt/rvalid port.
// Latency: accept->mem_req_o 1 cycle; store done 1 cycle after gnt; load rd_valid_o 1 cycle after rvalid.
// Backpressure: ready_o is 1 only in IDLE; mem_req_o and its fields stay stable until gnt.
// Ports: clk_i, arst_i (async, active-high), bus (mem_access_ctrl_if.slave).
// Optional MEM_TIMEOUT_EN: abort WAIT_RSP after TIMEOUT_CYCLES with an err_o pulse.
module mem_access_ctrl
    import simple_processor_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic             clk_i,
    input  logic             arst_i,
    mem_access_ctrl_if.slave bus
);

    mem_state_t            state_q,     state_d;
    func_t                 func_q,      func_d;
    logic                  ready_q,     ready_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
    logic                  rd_valid_q,  rd_valid_d;
    logic                  done_q,      done_d;

`ifdef MEM_TIMEOUT_EN
    logic err_q, err_d;
    logic wait_entry;
    logic timeout;

    // Entering WAIT_RSP is exactly a granted load.
    assign wait_entry = (state_q == REQ) && bus.mem_gnt_i && (func_q == LOAD);

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .clear_i   (wait_entry),
        .enable_i  (state_q == WAIT_RSP),
        .expired_o (timeout)
    );
`endif

    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        err_d       = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    func_d = bus.func_i;
                    if ((bus.func_i == LOAD) || ((bus.func_i == STORE) && bus.we_i)) begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (bus.func_i == STORE);
                        mem_addr_d  = align_word_addr(bus.addr_i);
                        mem_wdata_d = bus.wdata_i;
                    end else begin
                        // Store without write enable or unknown func: complete without touching memory.
                        done_d = 1'b1;
                    end
                end
            end

            REQ: begin
                // rvalid is not looked at here: memory cannot answer before the cycle after gnt.
                if (bus.mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    if (func_q == STORE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end

            WAIT_RSP: begin
                if (bus.mem_rvalid_i) begin
                    state_d    = IDLE;
                    rd_data_d  = bus.mem_rdata_i;
                    rd_valid_d = 1'b1;
                    done_d     = 1'b1;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end
`endif
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Registered ready: high exactly while the FSM sits in IDLE.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            func_q      <= LOAD;
            ready_q     <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            ready_q     <= ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.ready_o     = ready_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.rd_data_o   = rd_data_q;
    assign bus.rd_valid_o  = rd_valid_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios, then random transactions
// against a word-addressed memory model and a transaction-level expectation.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_ctrl;
    import simple_processor_pkg::*;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus_if)
    );

    logic [31:0] mem_model [logic [31:0]];

    // random-phase state
    int          cyc;
    int          gap;
    int          sel;
    int          rsp_wait;
    func_t       f;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] wa;
    logic [31:0] exp_rd;
    logic [31:0] exp_load;
    logic        is_load;
    logic        access;
    logic        granted;
    logic        outstanding;
    logic        done_seen;
    logic        quiet;

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        if (mem_model.exists(addr)) return mem_model[addr];
        return addr ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.valid_i      = 1'b0;
        bus_if.func_i       = LOAD;
        bus_if.we_i         = 1'b0;
        bus_if.addr_i       = '0;
        bus_if.wdata_i      = '0;
        bus_if.mem_gnt_i    = 1'b0;
        bus_if.mem_rvalid_i = 1'b0;
        bus_if.mem_rdata_i  = '0;
    endtask

    task automatic send(input func_t fn, input logic w, input logic [31:0] ad, input logic [31:0] dt);
        bus_if.valid_i = 1'b1;
        bus_if.func_i  = fn;
        bus_if.we_i    = w;
        bus_if.addr_i  = ad;
        bus_if.wdata_i = dt;
    endtask

    task automatic drive_stray();
        bus_if.mem_rvalid_i = ($urandom_range(0, 5) == 0);
        bus_if.mem_rdata_i  = $urandom;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 96'(bus_if.ready_o), 96'(1));
        check({tag, "_ctrl"}, 96'({bus_if.mem_req_o, bus_if.mem_we_o, bus_if.rd_valid_o,
                                   bus_if.done_o, bus_if.err_o}), 96'(0));
        check({tag, "_addr_wdata"}, 96'({bus_if.mem_addr_o, bus_if.mem_wdata_o}), 96'(0));
        check({tag, "_rdata"}, 96'(bus_if.rd_data_o), 96'(0));
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        arst = 1'b0;

        // 1: reset in the middle of a pending store
        @(negedge clk);
        send(STORE, 1'b1, 32'h0000_0A0C, 32'hCAFE_F00D);
        @(negedge clk);
        bus_if.valid_i = 1'b0;
        check("t1_req_before_rst", 96'(bus_if.mem_req_o), 96'(1));
        @(posedge clk);
        #2 arst = 1'b1;
        #1 check_reset_state("t1_async_rst");
        @(negedge clk);
        arst = 1'b0;

        // 2: store held off by three cycles of gnt low
        @(negedge clk);
        send(STORE, 1'b1, 32'h0000_0103, 32'hDEAD_BEEF);
        @(negedge clk);
        bus_if.valid_i = 1'b0;
        check("t2_busy", 96'(bus_if.ready_o), 96'(0));
        for (int i = 0; i < 4; i++) begin
            check("t2_req_hold", 96'({bus_if.mem_req_o, bus_if.mem_we_o, bus_if.mem_addr_o,
                                      bus_if.mem_wdata_o}),
                  96'({1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF}));
            check("t2_no_done", 96'(bus_if.done_o), 96'(0));
            bus_if.mem_gnt_i = (i == 3);
            @(negedge clk);
        end
        bus_if.mem_gnt_i = 1'b0;
        check("t2_done", 96'({bus_if.done_o, bus_if.mem_req_o, bus_if.ready_o}), 96'(3'b101));
        @(negedge clk);
        check("t2_done_pulse", 96'(bus_if.done_o), 96'(0));

        // 3: store without write enable
        send(STORE, 1'b0, 32'h0000_0200, 32'h1111_1111);
        @(negedge clk);
        bus_if.valid_i = 1'b0;
        check("t3_done", 96'({bus_if.done_o, bus_if.mem_req_o, bus_if.ready_o}), 96'(3'b101));
        @(negedge clk);
        check("t3_after", 96'({bus_if.done_o, bus_if.mem_req_o}), 96'(0));

        // 4: load with immediate gnt, rvalid two cycles later, then a store
        send(LOAD, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        bus_if.valid_i = 1'b0;
        check("t4_req", 96'({bus_if.mem_req_o, bus_if.mem_we_o, bus_if.mem_addr_o}),
              96'({1'b1, 1'b0, 32'h0000_0040}));
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        check("t4_wait1", 96'({bus_if.mem_req_o, bus_if.ready_o, bus_if.rd_valid_o}), 96'(0));
        @(negedge clk);
        check("t4_wait2", 96'({bus_if.ready_o, bus_if.rd_valid_o, bus_if.done_o}), 96'(0));
        bus_if.mem_rvalid_i = 1'b1;
        bus_if.mem_rdata_i  = 32'h1234_5678;
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        bus_if.mem_rdata_i  = '0;
        check("t4_rd", 96'({bus_if.rd_valid_o, bus_if.done_o, bus_if.ready_o, bus_if.rd_data_o}),
              96'({3'b111, 32'h1234_5678}));
        @(negedge clk);
        check("t4_rd_pulse", 96'({bus_if.rd_valid_o, bus_if.rd_data_o}), 96'({1'b0, 32'h1234_5678}));
        send(STORE, 1'b1, 32'h0000_0044, 32'h0000_0055);
        @(negedge clk);
        bus_if.valid_i   = 1'b0;
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        check("t4_st_done_hold", 96'({bus_if.done_o, bus_if.rd_valid_o, bus_if.rd_data_o}),
              96'({2'b10, 32'h1234_5678}));
        @(negedge clk);
        check("t4_hold", 96'(bus_if.rd_data_o), 96'(32'h1234_5678));

        // 5: reset while waiting for read data, then a stray rvalid
        send(LOAD, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge clk);
        bus_if.valid_i   = 1'b0;
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        check("t5_waiting", 96'(bus_if.ready_o), 96'(0));
        @(posedge clk);
        #2 arst = 1'b1;
        #1 check_reset_state("t5_async_rst");
        @(negedge clk);
        arst = 1'b0;
        bus_if.mem_rvalid_i = 1'b1;
        bus_if.mem_rdata_i  = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        check("t5_stray", 96'({bus_if.rd_valid_o, bus_if.done_o, bus_if.ready_o, bus_if.rd_data_o}),
              96'({3'b001, 32'h0}));
        exp_rd = 32'h0;

        // 6: load that never gets read data
        send(LOAD, 1'b0, 32'h0000_0300, 32'h0);
        @(negedge clk);
        bus_if.valid_i   = 1'b0;
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        quiet = 1'b1;
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k < 17; k++) begin
            quiet &= !(bus_if.err_o || bus_if.done_o || bus_if.ready_o);
            @(negedge clk);
        end
        check("t6_quiet_before_timeout", 96'(quiet), 96'(1));
        check("t6_timeout", 96'({bus_if.err_o, bus_if.done_o, bus_if.rd_valid_o, bus_if.ready_o,
                                 bus_if.rd_data_o}), 96'({4'b1101, 32'h0}));
        @(negedge clk);
        check("t6_err_pulse", 96'({bus_if.err_o, bus_if.done_o}), 96'(0));
`else
        for (int k = 1; k <= 40; k++) begin
            quiet &= !(bus_if.err_o || bus_if.done_o || bus_if.ready_o);
            if (k < 40) @(negedge clk);
        end
        check("t6_waits_forever", 96'(quiet), 96'(1));
        bus_if.mem_rvalid_i = 1'b1;
        bus_if.mem_rdata_i  = 32'h0BAD_CAFE;
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        check("t6_late_rsp", 96'({bus_if.rd_valid_o, bus_if.done_o, bus_if.err_o, bus_if.rd_data_o}),
              96'({3'b110, 32'h0BAD_CAFE}));
        exp_rd = 32'h0BAD_CAFE;
`endif

        // random transactions against the memory model
        cyc = 0;
        while (cyc < 5000) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                drive_stray();
                @(negedge clk);
                cyc++;
            end
            check("rnd_ready_idle", 96'(bus_if.ready_o), 96'(1));
            check("rnd_rd_hold", 96'(bus_if.rd_data_o), 96'(exp_rd));

            sel = $urandom_range(0, 9);
            if (sel < 4)       f = LOAD;
            else if (sel < 8)  f = STORE;
            else if (sel == 8) f = func_t'(2'd2);
            else               f = func_t'(2'd3);
            we      = ($urandom_range(0, 3) != 0);
            a       = $urandom_range(0, 255);
            d       = $urandom;
            wa      = {a[31:2], 2'b00};
            is_load = (f == LOAD);
            access  = is_load || ((f == STORE) && we);
            send(f, we, a, d);
            drive_stray();
            @(negedge clk);
            cyc++;
            bus_if.valid_i = 1'b0;

            done_seen   = 1'b0;
            granted     = 1'b0;
            outstanding = 1'b0;
            rsp_wait    = 0;
            for (int t = 0; t < 100 && !done_seen; t++) begin
                if (bus_if.done_o) begin
                    done_seen = 1'b1;
                    check("rnd_mem_access", 96'(granted), 96'(access));
                    check("rnd_done_state", 96'({bus_if.ready_o, bus_if.mem_req_o, bus_if.err_o,
                                                 bus_if.rd_valid_o}), 96'({3'b100, is_load}));
                    if (is_load) begin
                        check("rnd_load_data", 96'(bus_if.rd_data_o), 96'(exp_load));
                        exp_rd = exp_load;
                    end
                    bus_if.mem_gnt_i = 1'b0;
                    drive_stray();
                end else begin
                    check("rnd_busy", 96'({bus_if.ready_o, bus_if.rd_valid_o, bus_if.err_o}), 96'(0));
                    bus_if.mem_rvalid_i = 1'b0;
                    if (rsp_wait > 0) begin
                        rsp_wait--;
                        if (rsp_wait == 0) begin
                            bus_if.mem_rvalid_i = 1'b1;
                            bus_if.mem_rdata_i  = exp_load;
                        end
                    end else if (!outstanding) begin
                        drive_stray();
                    end
                    bus_if.mem_gnt_i = 1'b0;
                    if (bus_if.mem_req_o) begin
                        check("rnd_req_fields",
                              96'({bus_if.mem_we_o, bus_if.mem_addr_o, is_load ? 32'h0 : bus_if.mem_wdata_o}),
                              96'({!is_load, wa, is_load ? 32'h0 : d}));
                        if (!granted && ($urandom_range(0, 2) == 0)) begin
                            bus_if.mem_gnt_i = 1'b1;
                            granted = 1'b1;
                            if (is_load) begin
                                exp_load    = mem_read(wa);
                                rsp_wait    = $urandom_range(1, 4);
                                outstanding = 1'b1;
                            end else begin
                                mem_model[wa] = d;
                            end
                        end
                    end
                end
                if (!done_seen) begin
                    @(negedge clk);
                    cyc++;
                end
            end
            check("rnd_txn_completes", 96'(done_seen), 96'(1));
            if (!done_seen) begin
                cyc = 5000;
            end
        end

        idle_inputs();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
